// File: rtl/window_gen_3x3_stream.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a three-column
// shift window, followed by a single registered output stage with valid/ready.
module window_gen_3x3_stream #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pixel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [9*DATA_W-1:0] out_win,
  output logic                out_last
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO = ROW_W'(2);

  logic [DATA_W-1:0]   lb0 [IMG_W];
  logic [DATA_W-1:0]   lb1 [IMG_W];
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [DATA_W-1:0]   win [9];
  logic [DATA_W-1:0]   nxt [9];
  logic [DATA_W-1:0]   top;
  logic [DATA_W-1:0]   mid;
  logic [9*DATA_W-1:0] next_win;
  logic                accept;
  logic                emit;
  logic                last_pix;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign top      = lb1[col];
  assign mid      = lb0[col];
  assign emit     = accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign last_pix = (row == ROW_MAX) && (col == COL_MAX);

  // Window indices 0..8 are p1..p9; the new right column enters at p3/p6/p9.
  always_comb begin
    nxt[0] = win[1];
    nxt[1] = win[2];
    nxt[2] = top;
    nxt[3] = win[4];
    nxt[4] = win[5];
    nxt[5] = mid;
    nxt[6] = win[7];
    nxt[7] = win[8];
    nxt[8] = in_pixel;
    next_win = '0;
    for (int k = 0; k < 9; k++) begin
      next_win[k*DATA_W +: DATA_W] = nxt[k];
    end
  end

  // Line buffers are not reset; the row gate keeps stale contents from ever being emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= mid;
      lb0[col] <= in_pixel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_win   <= '0;
      for (int k = 0; k < 9; k++) begin
        win[k] <= '0;
      end
    end else begin
      if (accept) begin
        win <= nxt;
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
      if (emit) begin
        out_valid <= 1'b1;
        out_win   <= next_win;
        out_last  <= last_pix;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3_stream.sv
// Scoreboard bench for window_gen_3x3_stream on a 4x4 frame: a frame-array
// reference model queues expected windows, a monitor pops them on each transfer.
module tb_window_gen_3x3_stream;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam logic [9*DW-1:0] FIRST_WIN  = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
  localparam logic [9*DW-1:0] FRAME2_WIN = {8'd26, 8'd25, 8'd24, 8'd22, 8'd21, 8'd20, 8'd18, 8'd17, 8'd16};

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pixel;
  logic          out_valid;
  logic          out_ready;
  logic [9*DW-1:0] out_win;
  logic          out_last;

  typedef struct {
    logic [9*DW-1:0] win;
    logic            last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [DW-1:0] img [H][W];
  int            n_vec = 0;
  int            n_miss = 0;
  int            n_win = 0;
  int            m_idx = 0;
  bit            rand_ready = 0;
  bit            rand_gaps = 0;

  window_gen_3x3_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: remember the frame by (row, col) and cut the 3x3 patch directly.
  task automatic model_accept(input logic [DW-1:0] p);
    int   r;
    int   c;
    exp_t e;
    r = m_idx / W;
    c = m_idx % W;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        e.win[k*DW +: DW] = img[r-2+k/3][c-2+k%3];
      end
      e.last = (m_idx == W*H-1);
      exp_q.push_back(e);
    end
    m_idx = (m_idx + 1) % (W*H);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic applyStimulus(input logic [DW-1:0] p);
    bit done;
    done = 0;
    if (rand_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_pixel = p;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #2;
      if (in_ready) begin
        model_accept(p);
        done = 1;
      end
      tick();
    end
    if (!done) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL accept_timeout: pixel %0d not accepted within 200 cycles", p);
    end
  endtask

  task automatic send_frame(input int base, input bit random_px);
    for (int i = 0; i < W*H; i++) begin
      applyStimulus(random_px ? DW'($urandom) : DW'(base + i));
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int expect_n);
    in_valid = 1'b0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) tick();
    rand_ready = 0;
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("pending_windows", 72'(exp_q.size()), 72'(0));
    checkOutput("window_count", 72'(n_win), 72'(expect_n));
    #1;
    checkOutput("idle_out_valid", 72'(out_valid), 72'(0));
    n_win = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("[TB] FAIL spurious_window: got %h, expected no window", out_win);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("window", out_win, mon_e.win);
          checkOutput("last", 72'(out_last), 72'(mon_e.last));
        end
        n_win++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 72'(out_valid), 72'(0));
    checkOutput("reset_out_win", out_win, 72'(0));
    checkOutput("reset_out_last", 72'(out_last), 72'(0));
    checkOutput("reset_in_ready", 72'(in_ready), 72'(1));

    $display("[TB] continuous stream");
    for (int i = 0; i <= 10; i++) applyStimulus(DW'(i));
    #1;
    checkOutput("first_valid", 72'(out_valid), 72'(1));
    checkOutput("first_win", out_win, FIRST_WIN);
    for (int i = 11; i < 16; i++) applyStimulus(DW'(i));
    drain(4);

    $display("[TB] output stall");
    out_ready = 1'b0;
    for (int i = 0; i <= 10; i++) applyStimulus(DW'(i));
    in_pixel = 8'd11;
    in_valid = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #2;
      checkOutput("stall_valid", 72'(out_valid), 72'(1));
      checkOutput("stall_in_ready", 72'(in_ready), 72'(0));
      checkOutput("stall_win", out_win, FIRST_WIN);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 11; i < 16; i++) applyStimulus(DW'(i));
    drain(4);

    $display("[TB] gapped input");
    rand_gaps = 1;
    send_frame(0, 0);
    rand_gaps = 0;
    drain(4);

    $display("[TB] back-to-back frames");
    for (int i = 0; i <= 26; i++) applyStimulus(DW'(i));
    #1;
    checkOutput("frame2_first_win", out_win, FRAME2_WIN);
    for (int i = 27; i < 32; i++) applyStimulus(DW'(i));
    drain(8);

    $display("[TB] reset after pixel 9");
    for (int i = 0; i <= 9; i++) applyStimulus(DW'(i));
    do_reset();
    #1;
    checkOutput("post_reset_valid", 72'(out_valid), 72'(0));
    send_frame(0, 0);
    drain(4);

    $display("[TB] reset with pending window");
    out_ready = 1'b0;
    for (int i = 0; i <= 10; i++) applyStimulus(DW'(i));
    #1;
    checkOutput("pending_valid", 72'(out_valid), 72'(1));
    tick();
    do_reset();
    #1;
    checkOutput("rst_out_valid", 72'(out_valid), 72'(0));
    checkOutput("rst_out_win", out_win, 72'(0));
    checkOutput("rst_out_last", 72'(out_last), 72'(0));
    checkOutput("rst_in_ready", 72'(in_ready), 72'(1));
    out_ready = 1'b1;
    n_win = 0;
    send_frame(0, 0);
    drain(4);

    $display("[TB] random pixels with random backpressure");
    rand_gaps = 1;
    rand_ready = 1;
    for (int f = 0; f < 3; f++) send_frame(0, 1);
    rand_gaps = 0;
    drain(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3_stream.md
Name: window_gen_3x3_stream

Overview:
- Parametrised streaming successor to the fixed-size 3x3 window memory.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) of an IMG_W x IMG_H frame.
- Buffers two previous rows in internal line buffers and emits one 3x3 neighbourhood per valid (unpadded) centre position, with valid/ready backpressure and an end-of-frame marker.
- Sits between the pixel source and the convolution/filter datapath.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 256: frame width in pixels; must be at least 3.
- IMG_H, 256: frame height in rows; must be at least 3.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  pixel present on in_pixel.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pixel  in  DATA_W  input pixel, raster order.
- out_valid  out  1  window present on out_win.
- out_ready  in  1  downstream accepts the window this cycle.
- out_win  out  9*DATA_W  window p1..p9 packed LSB-first.
  - p1 is at bits [DATA_W-1:0]; p9 is at the top bits.
  - p1..p3: top row, left to right; p4..p6: middle row; p7..p9: bottom row.
- out_last  out  1  qualifies the final window of a frame; meaningful only with out_valid.

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high reset `rst`.
- Reset values: out_valid=0, out_last=0, out_win=0, column and row counters=0, window shift registers=0. Line-buffer RAM contents are not reset.
- in_ready = !out_valid || out_ready. This is combinational and gives a single output register stage with full throughput.
- Accept event: in_valid && in_ready. Counters and buffers change only on accept.
- On accept of the pixel at (r,c), addressed by col counter c:
  - top = lb1[c], mid = lb0[c], bot = in_pixel.
  - Write lb1[c] <= lb0[c] and lb0[c] <= in_pixel. Read-before-write at the same address.
  - Shift the window left one column; new right column = {top, mid, bot}.
- Col counter: increments per accept and wraps IMG_W-1 -> 0. Row counter increments on that wrap.
- Row counter: wraps IMG_H-1 -> 0 at frame end, so back-to-back frames need no idle cycle.
- Window emit: if r>=2 and c>=2 at accept, the next cycle drives out_valid=1 with the window covering rows r-2..r and cols c-2..c (p9 = the accepted pixel).
- Latency: 1 cycle from accept to out_valid.
- out_last=1 on the window whose accept had r=IMG_H-1 and c=IMG_W-1.
- Accepts with r<2 or c<2 update buffers only. Stale columns left over from the previous row are never emitted.
- Output handshake:
  - Transfer occurs when out_valid && out_ready.
  - If out_valid && !out_ready: out_win and out_last hold stable and in_ready=0.
  - Transfer with no new emitting accept in the same cycle: out_valid -> 0.
  - Transfer plus a simultaneous emitting accept: out_valid stays 1 with new data.
- out_win and out_last keep their last value when out_valid=0.
- Window count per frame: (IMG_W-2)*(IMG_H-2).
- Reset mid-frame: the pending window is dropped and counters return to 0. The next accepted pixel is treated as (0,0). Old line-buffer data is never emitted because row<2 gates output.
- Widths: col counter $clog2(IMG_W) bits, row counter $clog2(IMG_H) bits. No arithmetic on pixel data.
- Line buffers: two IMG_W x DATA_W arrays, single-cycle read/write, one read and one write per port per accept.

Test Plan:
All scenarios use IMG_W=4, IMG_H=4, DATA_W=8, and pixel value = 4r+c (0..15).
- Continuous stream, out_ready=1 -> exactly 4 windows.
  - First window is {0,1,2,4,5,6,8,9,10}, appearing 1 cycle after pixel 10 is accepted.
  - Next windows are {1,2,3,5,6,7,9,10,11}, then {4,5,6,8,9,10,12,13,14}.
  - Last window is {5,6,7,9,10,11,13,14,15} with out_last=1; out_last=0 on all other windows.
- out_ready=0 for 5 cycles while window {0..10} is pending -> out_win stays constant, in_ready=0, no pixels are consumed.
  - After release, the remaining 3 windows arrive in order with no loss or duplication.
- in_valid toggling randomly, out_ready=1 -> window contents identical to the continuous case. No window is emitted for pixels 0-9, 12 or 13.
- Two frames back-to-back with no gap, second frame values +16 -> 8 windows.
  - The second frame's first window is {16,17,18,20,21,22,24,25,26}; frame-1 rows never leak into it.
- rst=1 for one cycle after pixel 9, then a full new frame -> out_valid=0 the cycle after reset.
  - The new frame yields exactly the 4 windows of the first scenario.
- Reset values: assert rst with out_valid=1 -> next cycle out_valid=0, out_win=0, out_last=0, in_ready=1.
